// File: rtl/inverter_pipe_bank_if.sv
// Stream bundle for inverter_pipe_bank: input word with its transform controls,
// the output word, and the delivered-word counter.
interface inverter_pipe_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inv_mask;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output in_data, in_valid, inv_mask, mode, out_ready,
    input  in_ready, out_data, out_valid, xfer_count
  );

  modport slave (
    input  in_data, in_valid, inv_mask, mode, out_ready,
    output in_ready, out_data, out_valid, xfer_count
  );
endinterface

// File: rtl/inverter_pipe_bank.sv
// Multi-channel mask/invert/toggle transform feeding a stall-all valid/ready
// pipeline, with a saturating count of delivered words.
module inverter_pipe_bank #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  inverter_pipe_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_MASK   = 2'd0,
    MODE_ALL    = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            valid_q;
  logic                         tog_q;
  logic                         tog_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;
  logic [WIDTH-1:0]             stage0Data_d;
  logic                         adv;
  logic                         accept;
  logic                         deliver;
  mode_e                        modeSel;

  assign adv            = !valid_q[STAGES-1] | bus.out_ready;
  assign accept         = adv & bus.in_valid;
  assign deliver        = valid_q[STAGES-1] & bus.out_ready;
  assign modeSel        = mode_e'(bus.mode);

  assign bus.in_ready   = adv;
  assign bus.out_valid  = valid_q[STAGES-1];
  assign bus.out_data   = data_q[STAGES-1];
  assign bus.xfer_count = cnt_q;

  // Bubbles load zero data so an undriven in_data can never reach the output.
  always_comb begin
    stage0Data_d = '0;
    tog_d        = tog_q;
    if (bus.in_valid) begin
      case (modeSel)
        MODE_MASK:   stage0Data_d = bus.in_data ^ bus.inv_mask;
        MODE_ALL:    stage0Data_d = ~bus.in_data;
        MODE_TOGGLE: begin
          stage0Data_d = {WIDTH{~tog_q}};
          tog_d        = ~tog_q;
        end
        MODE_BYPASS: stage0Data_d = bus.in_data;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // All stages shift together on adv, bubbles included, and hold together otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (adv) begin
        data_q[0]  <= stage0Data_d;
        valid_q[0] <= bus.in_valid;
        for (int s = 1; s < STAGES; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
      if (accept) begin
        tog_q <= tog_d;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inverter_pipe_bank.sv
// Directed bench for inverter_pipe_bank (WIDTH=8, STAGES=2, CNT_W=3): inputs
// change on the falling edge, outputs are checked on the falling edge.
module tb_inverter_pipe_bank;

  localparam logic [1:0] MASK   = 2'd0;
  localparam logic [1:0] ALL    = 2'd1;
  localparam logic [1:0] TOGGLE = 2'd2;
  localparam logic [1:0] BYPASS = 2'd3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inverter_pipe_bank_if #(.WIDTH(8), .CNT_W(3)) bus ();

  inverter_pipe_bank #(.WIDTH(8), .STAGES(2), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] m,
                               input logic [7:0] msk, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode      = m;
    bus.inv_mask  = msk;
    bus.out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int got;

    // Reset held three cycles with a valid word presented
    rst = 1'b1;
    applyStimulus(1'b1, 8'h77, MASK, 8'hFF, 1'b1);
    repeat (3) nextCycle();
    checkOutput("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h00);
    checkOutput("rst_count", 32'(bus.xfer_count), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // MASK then ALL, two-cycle latency
    applyStimulus(1'b1, 8'hA5, MASK, 8'h0F, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'h3C, ALL, 8'h00, 1'b1);
    nextCycle();
    checkOutput("mask_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mask_data", 32'(bus.out_data), 32'hAA);
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("all_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("all_data", 32'(bus.out_data), 32'hC3);
    nextCycle();
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("count_two", 32'(bus.xfer_count), 32'd2);

    // Backpressure: 01..05 in BYPASS, out_ready low for loop iterations 3..6
    idx = 0;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      applyStimulus(idx < 5, 8'(idx + 1), BYPASS, 8'h00, !(c >= 3 && c < 7));
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_hold_data", 32'(bus.out_data), 32'h02);
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("bp_order", 32'(bus.out_data), 32'(got + 1));
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      nextCycle();
    end
    checkOutput("bp_delivered", 32'(got), 32'd5);
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("bp_count", 32'(bus.xfer_count), 32'd7);

    // TOGGLE from reset, BYPASS in between leaves tog_q alone
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("tog_rst_count", 32'(bus.xfer_count), 32'd0);
    applyStimulus(1'b1, 8'h33, TOGGLE, 8'h00, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'h33, TOGGLE, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_1", 32'(bus.out_data), 32'hFF);
    applyStimulus(1'b1, 8'h33, TOGGLE, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_2", 32'(bus.out_data), 32'h00);
    applyStimulus(1'b1, 8'h33, TOGGLE, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_3", 32'(bus.out_data), 32'hFF);
    applyStimulus(1'b1, 8'h5A, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_4", 32'(bus.out_data), 32'h00);
    applyStimulus(1'b1, 8'h33, TOGGLE, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_bypass", 32'(bus.out_data), 32'h5A);
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("tog_5", 32'(bus.out_data), 32'hFF);
    checkOutput("tog_5_valid", 32'(bus.out_valid), 32'd1);
    nextCycle();
    checkOutput("tog_drain", 32'(bus.out_valid), 32'd0);

    // Mode change between back-to-back words
    applyStimulus(1'b1, 8'h0F, ALL, 8'h00, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'h0F, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("mc_first", 32'(bus.out_data), 32'hF0);
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("mc_second", 32'(bus.out_data), 32'h0F);
    checkOutput("mc_second_valid", 32'(bus.out_valid), 32'd1);

    // Saturation at 7 after nine transfers
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(i), BYPASS, 8'h00, 1'b1);
      nextCycle();
      if (i == 5) checkOutput("sat_mid_count", 32'(bus.xfer_count), 32'd4);
    end
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    repeat (3) nextCycle();
    checkOutput("sat_count", 32'(bus.xfer_count), 32'd7);

    // Reset with two words in flight discards both
    applyStimulus(1'b1, 8'hAA, BYPASS, 8'h00, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'hBB, BYPASS, 8'h00, 1'b1);
    nextCycle();
    checkOutput("flight_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, BYPASS, 8'h00, 1'b1);
    checkOutput("mrst_count", 32'(bus.xfer_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("mrst_no_word", 32'(bus.out_valid), 32'd0);
    end
    checkOutput("mrst_count_after", 32'(bus.xfer_count), 32'd0);
    checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
